// File: rtl/cache_join2_ctrl.sv
`default_nettype none
// ============================================================================
// cache_join2_ctrl : two-channel token join with starvation flag and merge count
// Revision 1.0
// ============================================================================
module cache_join2_ctrl #(
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 200,
    parameter int TMO_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in0_valid,
    input  logic [DATA_W-1:0]   in0_data,
    output logic                in0_ready,
    input  logic                in1_valid,
    input  logic [DATA_W-1:0]   in1_data,
    output logic                in1_ready,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] out_data,
    input  logic                out_ready,
    input  logic                clr_err,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    merge_cnt
);

    // State bit k is the full flag of slot k.
    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_HAVE0 = 2'b01;
    localparam logic [1:0] c_HAVE1 = 2'b10;
    localparam logic [1:0] c_FULL  = 2'b11;

    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] c_TMO_MAX  = {TMO_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] slot0_q, slot1_q;
    logic [TMO_W-1:0]  wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic w_fire, w_acc0, w_acc1, w_waiting, w_tmo_set;

    assign out_valid = (state_q == c_FULL);
    assign w_fire    = out_valid & out_ready;
    assign in0_ready = ~state_q[0] | w_fire;
    assign in1_ready = ~state_q[1] | w_fire;
    assign w_acc0    = in0_valid & in0_ready;
    assign w_acc1    = in1_valid & in1_ready;

    assign w_waiting = (state_q == c_HAVE0) || (state_q == c_HAVE1);
    assign w_tmo_set = w_waiting && (wait_q == c_TMO_LAST);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        // A slot stays full unless its token leaves; a new accept refills it.
        state_d[0] = w_acc0 | (state_q[0] & ~w_fire);
        state_d[1] = w_acc1 | (state_q[1] & ~w_fire);
        if (w_waiting) begin
            wait_d = (wait_q == c_TMO_MAX) ? wait_q : wait_q + TMO_W'(1);
        end
        err_d = w_tmo_set | (err_q & ~clr_err);
        cnt_d = cnt_q + CNT_W'(w_fire);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= c_IDLE;
            slot0_q <= '0;
            slot1_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (w_acc0) begin
                slot0_q <= in0_data;
            end
            if (w_acc1) begin
                slot1_q <= in1_data;
            end
        end
    end

    assign out_data    = {slot1_q, slot0_q};
    assign timeout_err = err_q;
    assign merge_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: doc/cache_join2_ctrl.md
Name: cache_join2_ctrl

Overview:
- Clocked two-channel join controller for the cache control path.
- Holds one token per requester channel, each with a DATA_W payload.
- Emits a single merged word {data1, data0} only when both channels have delivered a token and downstream accepts it.
- Adds starvation detection (one side waiting too long) and a merge counter for debug and performance visibility.

Parameters:
- DATA_W, 1, payload width per channel.
- TIMEOUT, 200, cycles one slot may wait alone before timeout_err sets (1..2^TMO_W-1).
- TMO_W, 8, width of the wait counter.
- CNT_W, 16, width of merge_cnt.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  synchronous active-low reset, sampled on rising clk.
- in0_valid  in  1  channel 0 token offered.
- in0_data  in  DATA_W  channel 0 payload.
- in0_ready  out  1  channel 0 slot can accept this cycle.
- in1_valid  in  1  channel 1 token offered.
- in1_data  in  DATA_W  channel 1 payload.
- in1_ready  out  1  channel 1 slot can accept this cycle.
- out_valid  out  1  merged token available.
- out_data  out  2*DATA_W  {slot1_data, slot0_data}.
- out_ready  in  1  downstream accepts merged token.
- clr_err  in  1  clears sticky timeout_err.
- timeout_err  out  1  sticky starvation flag.
- merge_cnt  out  CNT_W  number of completed merges, wraps.

Behaviour:
- Reset: on a rising clk with rstn=0, all of the following clear; any held tokens are dropped, including mid-wait. Reset has priority over all other events.
  - state=IDLE, slot data=0, out_valid=0, out_data=0.
  - wait_cnt=0, timeout_err=0, merge_cnt=0.
  - in0_ready=in1_ready=1 from the first cycle after reset.
- States (encode the slot-full flags): IDLE (none held), HAVE0 (slot0 only), HAVE1 (slot1 only), FULL (both held).
- Handshakes:
  - acc_k = in_k_valid & in_k_ready.
  - fire = out_valid & out_ready.
- Outputs:
  - out_valid = (state==FULL), registered-state driven with no combinational path from inputs.
  - out_data = {slot1, slot0}, held stable while out_valid=1 and out_ready=0.
  - in_k_ready = ~full_k | fire, so a slot refills in the same cycle its old token leaves.
- Transitions:
  - IDLE: acc0&acc1 -> FULL; acc0 -> HAVE0; acc1 -> HAVE1.
  - HAVE0: acc1 -> FULL. A second channel-0 token is blocked because in0_ready=0.
  - HAVE1: symmetric to HAVE0.
  - FULL & fire: next state from that cycle's accepts (both -> FULL, acc0 -> HAVE0, acc1 -> HAVE1, none -> IDLE).
  - FULL & ~fire: hold.
- Data capture: slot_k <= in_k_data on acc_k.
- Latency: from the cycle both tokens are accepted to out_valid=1 is 1 cycle. With both channels valid every cycle and out_ready=1, throughput is one merge per cycle.
- Starvation counter:
  - wait_cnt increments each cycle state is HAVE0 or HAVE1, saturating at 2^TMO_W-1.
  - It clears to 0 in IDLE and FULL.
  - When wait_cnt==TIMEOUT-1 while still waiting, timeout_err sets on the next edge.
  - timeout_err stays set until clr_err=1; if set and clear coincide, set wins.
  - The token is never discarded on timeout.
- merge_cnt increments by 1 on each fire and wraps modulo 2^CNT_W.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles -> out_valid=0, in0_ready=in1_ready=1, merge_cnt=0, timeout_err=0.
- Staggered join: in0 data=1 at cycle 0, in1 data=0 at cycle 3, out_ready=1 -> out_valid=1 at cycle 4 with out_data=2'b01, in0_ready=0 during cycles 1-3, merge_cnt=1.
- Back-pressure and refill: both valid every cycle, out_ready=0 for 3 cycles then 1 -> out_data held constant while stalled; after release, one merge per cycle, and refill occurs in the fire cycle.
- Timeout: TIMEOUT=5, only in1 sends -> timeout_err=1 five cycles after entering HAVE1. Send in0 -> merge completes and timeout_err stays 1. Pulse clr_err -> timeout_err=0.
- Reset mid-operation: reset in HAVE0 with slot0=1 -> state IDLE; the next merge carries only new data.
- Counter wrap: CNT_W=4, 17 merges -> merge_cnt=1.
